// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the ALU operand loader: FSM states, opcode encodings, frame geometry.
// Opcode validation helper is used only when ALU_OPCODE_CHECK_EN is defined.
package alu_operand_loader_pkg;

    typedef enum logic [1:0] {
        ST_OP     = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_ISSUE  = 2'd3
    } state_e;

    localparam logic [2:0] OPC_AND  = 3'b000;
    localparam logic [2:0] OPC_OR   = 3'b001;
    localparam logic [2:0] OPC_ADD  = 3'b010;
    localparam logic [2:0] OPC_SUB  = 3'b011;
    localparam logic [2:0] OPC_NAND = 3'b100;
    localparam logic [2:0] OPC_MUL  = 3'b111;

    localparam int unsigned FRAME_BYTES   = 9;
    localparam int unsigned OPERAND_BYTES = 4;

    // Reserved bits must be zero and sel must not be one of the two unassigned codes.
    function automatic logic opcode_valid(input logic [7:0] op);
        return (op[7:3] == 5'd0) && (op[2:0] != 3'b101) && (op[2:0] != 3'b110);
    endfunction

endpackage

// File: rtl/alu_operand_loader.sv
// Assembles 9-byte frames (opcode, operand A, operand B) into one ALU operation with a
// valid/ready handshake. Optional opcode validation: define ALU_OPCODE_CHECK_EN.
module alu_operand_loader
    import alu_operand_loader_pkg::*;
#(
    parameter int unsigned LITTLE_ENDIAN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  sel,
    output logic        enable,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err
);

`ifdef ALU_OPCODE_CHECK_EN
    localparam bit OpcodeCheck = 1'b1;
`else
    localparam bit OpcodeCheck = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  sel_sh_q, sel_sh_d;
    logic [31:0] a_sh_q, a_sh_d;
    logic [31:0] b_sh_q, b_sh_d;
    logic        op_ok_q, op_ok_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  sel_q, sel_d;
    logic        out_valid_q, out_valid_d;
    logic        err_q, err_d;

    logic        accept;
    logic        last_byte;
    logic [1:0]  lane;
    logic [31:0] a_wr;
    logic [31:0] b_wr;

    assign in_ready  = (state_q != ST_ISSUE);
    assign accept    = in_valid && in_ready;
    assign last_byte = (cnt_q == 2'(OPERAND_BYTES - 1));

    // Big-endian puts the first operand byte in the top lane: lane = 3 - cnt.
    assign lane = (LITTLE_ENDIAN != 0) ? cnt_q : ~cnt_q;

    always_comb begin
        a_wr = a_sh_q;
        b_wr = b_sh_q;
        a_wr[{lane, 3'b000} +: 8] = in_data;
        b_wr[{lane, 3'b000} +: 8] = in_data;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_sh_d    = sel_sh_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        op_ok_d     = op_ok_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;

        unique case (state_q)
            ST_OP: begin
                if (accept) begin
                    sel_sh_d = in_data[2:0];
                    op_ok_d  = !OpcodeCheck || opcode_valid(in_data);
                    cnt_d    = 2'd0;
                    state_d  = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                if (accept) begin
                    a_sh_d = a_wr;
                    cnt_d  = cnt_q + 2'd1;
                    if (last_byte) begin
                        cnt_d   = 2'd0;
                        state_d = ST_LOAD_B;
                    end
                end
            end
            ST_LOAD_B: begin
                if (accept) begin
                    b_sh_d = b_wr;
                    cnt_d  = cnt_q + 2'd1;
                    if (last_byte) begin
                        cnt_d = 2'd0;
                        // Outputs only change when a frame is actually issued.
                        if (op_ok_q) begin
                            a_d         = a_sh_q;
                            b_d         = b_wr;
                            sel_d       = sel_sh_q;
                            out_valid_d = 1'b1;
                            state_d     = ST_ISSUE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_OP;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_OP;
                end
            end
            default: state_d = ST_OP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OP;
            cnt_q       <= 2'd0;
            sel_sh_q    <= 3'd0;
            a_sh_q      <= 32'd0;
            b_sh_q      <= 32'd0;
            op_ok_q     <= 1'b1;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            sel_q       <= 3'd0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_sh_q    <= sel_sh_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            op_ok_q     <= op_ok_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign enable    = out_valid_q;
    assign err       = OpcodeCheck ? err_q : 1'b0;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader: drives one little-endian and one big-endian
// instance from the same byte stream and checks against hand-computed values.
module tb_alu_operand_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_le, in_ready_be;
    logic [31:0] a_le, b_le, a_be, b_be;
    logic [2:0]  sel_le, sel_be;
    logic        enable_le, enable_be;
    logic        out_valid_le, out_valid_be;
    logic        err_le, err_be;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_operand_loader #(.LITTLE_ENDIAN(1)) dut_le (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_le),
        .a         (a_le),
        .b         (b_le),
        .sel       (sel_le),
        .enable    (enable_le),
        .out_valid (out_valid_le),
        .out_ready (out_ready),
        .err       (err_le)
    );

    alu_operand_loader #(.LITTLE_ENDIAN(0)) dut_be (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_be),
        .a         (a_be),
        .b         (b_be),
        .sel       (sel_be),
        .enable    (enable_be),
        .out_valid (out_valid_be),
        .out_ready (out_ready),
        .err       (err_be)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called between clock edges; returns 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] d);
        int n;
        n        = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready_le && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("send_timeout_in_ready", {31'd0, in_ready_le}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // fr[71:64] is the first byte on the wire.
    task automatic send_frame(input logic [71:0] fr, input bit gap);
        for (int i = 0; i < 9; i++) begin
            send_byte(fr[71-8*i -: 8]);
            if (gap && i < 8) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        #12;
        check_eq("rst_a",         a_le, 32'h0);
        check_eq("rst_b",         b_le, 32'h0);
        check_eq("rst_sel",       {29'd0, sel_le}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid_le}, 32'd0);
        check_eq("rst_enable",    {31'd0, enable_le}, 32'd0);
        check_eq("rst_err",       {31'd0, err_le}, 32'd0);
        check_eq("rst_in_ready",  {31'd0, in_ready_le}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ADD frame, both byte orders.
        send_frame(72'h02_01000000_02000000, 1'b0);
        check_eq("f1_out_valid", {31'd0, out_valid_le}, 32'd1);
        check_eq("f1_enable",    {31'd0, enable_le}, 32'd1);
        check_eq("f1_sel",       {29'd0, sel_le}, 32'd2);
        check_eq("f1_a_le",      a_le, 32'h0000_0001);
        check_eq("f1_b_le",      b_le, 32'h0000_0002);
        check_eq("f1_a_be",      a_be, 32'h0100_0000);
        check_eq("f1_b_be",      b_be, 32'h0200_0000);
        check_eq("f1_in_ready",  {31'd0, in_ready_le}, 32'd0);

        // Downstream backpressure with input still offered.
        in_data  = 8'hAA;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("stall_in_ready",  {31'd0, in_ready_le}, 32'd0);
            check_eq("stall_out_valid", {31'd0, out_valid_le}, 32'd1);
            check_eq("stall_a",         a_le, 32'h0000_0001);
            check_eq("stall_b",         b_le, 32'h0000_0002);
        end
        in_valid = 1'b0;
        handshake();
        check_eq("hs_out_valid", {31'd0, out_valid_le}, 32'd0);
        check_eq("hs_enable",    {31'd0, enable_le}, 32'd0);
        check_eq("hs_in_ready",  {31'd0, in_ready_le}, 32'd1);
        check_eq("hs_a_kept",    a_le, 32'h0000_0001);
        check_eq("hs_sel_kept",  {29'd0, sel_le}, 32'd2);

        // Same frame with idle cycles between bytes.
        send_frame(72'h02_01000000_02000000, 1'b1);
        check_eq("gap_out_valid", {31'd0, out_valid_le}, 32'd1);
        check_eq("gap_sel",       {29'd0, sel_le}, 32'd2);
        check_eq("gap_a_le",      a_le, 32'h0000_0001);
        check_eq("gap_b_le",      b_le, 32'h0000_0002);
        check_eq("gap_b_be",      b_be, 32'h0200_0000);
        handshake();

        // Opcode 0x05: unassigned sel.
        send_frame(72'h05_11223344_55667788, 1'b0);
`ifdef ALU_OPCODE_CHECK_EN
        check_eq("op05_err",       {31'd0, err_le}, 32'd1);
        check_eq("op05_out_valid", {31'd0, out_valid_le}, 32'd0);
        check_eq("op05_in_ready",  {31'd0, in_ready_le}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("op05_err_pulse", {31'd0, err_le}, 32'd0);
        check_eq("op05_a_kept",    a_le, 32'h0000_0001);
        check_eq("op05_b_kept",    b_le, 32'h0000_0002);
        check_eq("op05_sel_kept",  {29'd0, sel_le}, 32'd2);
`else
        check_eq("op05_err",       {31'd0, err_le}, 32'd0);
        check_eq("op05_out_valid", {31'd0, out_valid_le}, 32'd1);
        check_eq("op05_sel",       {29'd0, sel_le}, 32'd5);
        check_eq("op05_a_le",      a_le, 32'h4433_2211);
        check_eq("op05_b_le",      b_le, 32'h8877_6655);
        check_eq("op05_a_be",      a_be, 32'h1122_3344);
        handshake();
`endif

        // Opcode 0x0F: reserved bit set.
        send_frame(72'h0F_11223344_55667788, 1'b0);
`ifdef ALU_OPCODE_CHECK_EN
        check_eq("op0f_err",       {31'd0, err_le}, 32'd1);
        check_eq("op0f_out_valid", {31'd0, out_valid_le}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("op0f_err_pulse", {31'd0, err_le}, 32'd0);
        check_eq("op0f_a_kept",    a_le, 32'h0000_0001);
        check_eq("op0f_sel_kept",  {29'd0, sel_le}, 32'd2);
`else
        check_eq("op0f_err",       {31'd0, err_le}, 32'd0);
        check_eq("op0f_out_valid", {31'd0, out_valid_le}, 32'd1);
        check_eq("op0f_sel",       {29'd0, sel_le}, 32'd7);
        check_eq("op0f_b_be",      b_be, 32'h5566_7788);
        handshake();
`endif

        // Reset after six bytes discards the partial frame.
        send_byte(8'h07);
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        send_byte(8'h03);
        rst_n = 1'b0;
        #2;
        check_eq("mrst_a",         a_le, 32'h0);
        check_eq("mrst_b",         b_le, 32'h0);
        check_eq("mrst_sel",       {29'd0, sel_le}, 32'd0);
        check_eq("mrst_out_valid", {31'd0, out_valid_le}, 32'd0);
        check_eq("mrst_enable",    {31'd0, enable_le}, 32'd0);
        check_eq("mrst_err",       {31'd0, err_le}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mrst_err_after", {31'd0, err_le}, 32'd0);

        send_frame(72'h07_FFFFFFFF_03000000, 1'b0);
        check_eq("f4_out_valid", {31'd0, out_valid_le}, 32'd1);
        check_eq("f4_sel",       {29'd0, sel_le}, 32'd7);
        check_eq("f4_a_le",      a_le, 32'hFFFF_FFFF);
        check_eq("f4_b_le",      b_le, 32'h0000_0003);
        check_eq("f4_b_be",      b_be, 32'h0300_0000);

        // Byte offered during the handshake cycle must wait one cycle.
        in_data   = 8'h03;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("b2b_out_valid", {31'd0, out_valid_le}, 32'd0);
        check_eq("b2b_in_ready",  {31'd0, in_ready_le}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'h00);
        check_eq("b2b_frame_valid", {31'd0, out_valid_le}, 32'd1);
        check_eq("b2b_sel",         {29'd0, sel_le}, 32'd3);
        check_eq("b2b_a",           a_le, 32'h0);
        check_eq("b2b_b",           b_le, 32'h0);
        handshake();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 Parameter LITTLE_ENDIAN, default 1, operand byte order (1: first byte = bits 7:0; 0: first byte = bits 31:24) SHALL be supported.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_data  input  8  byte stream carrying opcode and operands.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  loader accepts a byte this cycle.
REQ-007 a  output  32  operand A to the ALU stage.
REQ-008 b  output  32  operand B to the ALU stage.
REQ-009 sel  output  3  ALU operation select.
REQ-010 enable  output  1  ALU enable; asserted exactly while out_valid is 1.
REQ-011 out_valid  output  1  a, b, sel hold a complete operation.
REQ-012 out_ready  input  1  downstream consumed the operation.
REQ-013 err  output  1  one-cycle pulse on rejected frame (tied 0 when REQ-030 feature is off).

Function
REQ-014 Frame SHALL be 9 bytes: byte 0 opcode (bits 2:0 = sel, bits 7:3 reserved), bytes 1-4 operand A, bytes 5-8 operand B.
REQ-015 A byte SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-016 FSM states SHALL be OP, LOAD_A, LOAD_B, ISSUE.
REQ-017 OP: accept byte -> latch sel from bits 2:0, go LOAD_A, byte counter = 0.
REQ-018 LOAD_A: each accepted byte written into A at counter lane per LITTLE_ENDIAN; counter increments; 4th byte -> LOAD_B, counter = 0.
REQ-019 LOAD_B: same rule for B; 4th byte -> ISSUE, out_valid = 1 on the next cycle (one-cycle latency from last byte).
REQ-020 in_ready SHALL be 1 in OP, LOAD_A, LOAD_B; 0 in ISSUE.
REQ-021 ISSUE: a, b, sel, out_valid held stable until out_ready = 1; that cycle completes transfer, next state OP, out_valid = 0 next cycle.
REQ-022 out_ready while out_valid = 0 SHALL be ignored.
REQ-023 Stalls (in_valid = 0) mid-frame SHALL hold state and counter indefinitely; no timeout.
REQ-024 a, b, sel SHALL retain last issued values outside ISSUE; new bytes land in shadow registers, copied to outputs on entry to ISSUE.
REQ-025 Back-to-back: byte 0 of the next frame SHALL be accepted the cycle after the out_ready handshake, not the same cycle.

Reset
REQ-026 rst_n low SHALL immediately force state OP, counter 0, a = 0, b = 0, sel = 0, out_valid = 0, enable = 0, err = 0, in_ready = 1 after deassertion.
REQ-027 Reset mid-frame or in ISSUE SHALL discard the partial/pending operation with no err pulse.

Configuration
REQ-028 Macro ALU_OPCODE_CHECK_EN SHALL control opcode validation.
REQ-029 Without it: every opcode byte accepted, sel = bits 2:0, reserved bits ignored, err constant 0.
REQ-030 With it: opcode invalid if bits 7:3 nonzero or sel in {101, 110}; frame still consumes all 9 bytes, but ISSUE skipped, err pulses 1 cycle after 9th byte, outputs unchanged, return to OP.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, opcode constants (AND 000, OR 001, NAND 100, ADD 010, SUB 011, MUL 111) and FRAME_BYTES = 9.
REQ-032 Single module; no sub-module (word assembler is inline).

Verification
REQ-033 Frame 02, 01 00 00 00, 02 00 00 00, LITTLE_ENDIAN=1 -> out_valid next cycle after byte 9, sel = 010, a = 0x00000001, b = 0x00000002, enable = 1.
REQ-034 Same bytes, LITTLE_ENDIAN=0 -> a = 0x01000000, b = 0x02000000.
REQ-035 out_ready held 0 for 5 cycles in ISSUE with in_valid = 1 -> in_ready = 0, outputs stable, no byte consumed; out_ready = 1 -> out_valid = 0 next cycle.
REQ-036 in_valid toggling every other cycle across a frame -> identical result to REQ-033, completion delayed accordingly.
REQ-037 ALU_OPCODE_CHECK_EN defined, opcode 0x05 then 8 bytes -> no out_valid, err = 1 for one cycle, a/b/sel keep previous values; opcode 0x0F likewise rejected.
REQ-038 rst_n pulsed low after byte 6 -> all outputs 0; following full frame 07, FF FF FF FF, 03 00 00 00 -> sel = 111, a = 0xFFFFFFFF, b = 0x00000003.
